// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU (S1 operand regs -> S2 result reg) with a retire-time {Z,V,N} flag register.
// Define ALU_PIPE_MUL_EN to add the iterative shift-add multiplier on opcode 1011.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flag
);
    localparam int SHW   = $clog2(WIDTH);
    localparam int NLANE = WIDTH / LANE;

    typedef enum logic [1:0] {UPD_NONE = 2'b00, UPD_Z = 2'b01, UPD_ALL = 2'b11} upd_e;

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic [2:0]       s2_flags_q, s2_flags_d;
    upd_e             s2_upd_q, s2_upd_d;
    logic [2:0]       flag_q, flag_d;

    logic             s1_adv, accept, retire, mul_ok;
    logic [WIDTH-1:0] alu_res, bb, sum, padd;
    logic             alu_v;
    upd_e             alu_upd;
    logic [SHW-1:0]   sh;

    // Per-lane signed saturating add for PADDSB
    for (genvar l = 0; l < NLANE; l++) begin : g_lane
        logic [LANE-1:0] la, lb, ls;
        logic            ovf;
        assign la  = s1_a_q[l*LANE +: LANE];
        assign lb  = s1_b_q[l*LANE +: LANE];
        assign ls  = la + lb;
        assign ovf = (la[LANE-1] == lb[LANE-1]) && (ls[LANE-1] != la[LANE-1]);
        assign padd[l*LANE +: LANE] = !ovf ? ls :
                                      la[LANE-1] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int CNTW = SHW + 1;
    logic [2*WIDTH-1:0] mul_acc_q, mul_acc_d, mul_mcand_q, mul_mcand_d;
    logic [WIDTH-1:0]   mul_mplier_q, mul_mplier_d;
    logic [CNTW-1:0]    mul_cnt_q, mul_cnt_d;

    assign mul_ok = !(s1_op_q == 4'b1011 && mul_cnt_q != '0);

    // Multiplier is loaded on accept and iterates while S1 holds the beat
    always_comb begin
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        mul_cnt_d    = mul_cnt_q;
        if (accept && op == 4'b1011) begin
            mul_acc_d    = '0;
            mul_mcand_d  = {{WIDTH{1'b0}}, a};
            mul_mplier_d = b;
            mul_cnt_d    = CNTW'(WIDTH);
        end else if (mul_cnt_q != '0) begin
            if (mul_mplier_q[0]) mul_acc_d = mul_acc_q + mul_mcand_q;
            mul_mcand_d  = mul_mcand_q << 1;
            mul_mplier_d = mul_mplier_q >> 1;
            mul_cnt_d    = mul_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_cnt_q    <= '0;
        end else begin
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
            mul_cnt_q    <= mul_cnt_d;
        end
    end
`else
    assign mul_ok = 1'b1;
`endif

    always_comb begin
        sh      = s1_b_q[SHW-1:0];
        bb      = (s1_op_q == 4'b0001) ? ~s1_b_q : s1_b_q;
        sum     = s1_a_q + bb + {{(WIDTH-1){1'b0}}, (s1_op_q == 4'b0001)};
        alu_res = '0;
        alu_v   = 1'b0;
        alu_upd = UPD_NONE;
        case (s1_op_q)
            4'b0000, 4'b0001: begin
                alu_res = sum;
                alu_v   = (s1_a_q[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
                alu_upd = UPD_ALL;
            end
            4'b0010: begin alu_res = s1_a_q ^ s1_b_q;                       alu_upd = UPD_Z; end
            4'b0100: begin alu_res = s1_a_q << sh;                          alu_upd = UPD_Z; end
            4'b0101: begin alu_res = WIDTH'($signed(s1_a_q) >>> sh);        alu_upd = UPD_Z; end
            4'b0110: begin alu_res = WIDTH'({s1_a_q, s1_a_q} >> sh);        alu_upd = UPD_Z; end
            4'b0111: begin alu_res = padd;                                  alu_upd = UPD_Z; end
            4'b1000: alu_res = {s1_a_q[WIDTH-1:8], s1_b_q[7:0]};
            4'b1001: alu_res = {s1_b_q[7:0], s1_a_q[WIDTH-9:0]};
            4'b1010: alu_res = (s1_a_q & ~WIDTH'(1)) + (s1_b_q << 1);
`ifdef ALU_PIPE_MUL_EN
            4'b1011: begin
                alu_res = mul_acc_q[WIDTH-1:0];
                alu_v   = |mul_acc_q[2*WIDTH-1:WIDTH];
                alu_upd = UPD_ALL;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        s1_adv   = s1_valid_q && (!s2_valid_q || out_ready) && mul_ok;
        in_ready = !s1_valid_q || s1_adv;
        accept   = in_valid && in_ready;
        retire   = s2_valid_q && out_ready;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op;
            s1_a_d     = a;
            s1_b_d     = b;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        s2_upd_d    = s2_upd_q;
        if (s1_adv) begin
            s2_valid_d  = 1'b1;
            s2_result_d = alu_res;
            s2_flags_d  = {(alu_res == '0), alu_v, alu_res[WIDTH-1]};
            s2_upd_d    = alu_upd;
        end else if (retire) begin
            s2_valid_d = 1'b0;
        end

        // Flags commit only when the result actually leaves S2
        flag_d = flag_q;
        if (retire) begin
            case (s2_upd_q)
                UPD_ALL: flag_d    = s2_flags_q;
                UPD_Z:   flag_d[2] = s2_flags_q[2];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            s2_upd_q    <= UPD_NONE;
            flag_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
            s2_upd_q    <= s2_upd_d;
            flag_q      <= flag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_result_q;
    assign flag      = flag_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=16, LANE=4): latency, opcode results, flags, backpressure, reset.
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  op;
    logic [15:0] a, b, result;
    logic [2:0]  flag;
    int          n_chk = 0, n_fail = 0;

    alu_pipe #(.WIDTH(16), .LANE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flag(flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        in_valid = 1'b1; op = o; a = x; b = y;
    endtask

    // Back-to-back opcode table; flags carried from the preceding tests (000 on entry)
    logic [3:0]  t_op  [12] = '{4'h7, 4'h5, 4'h6, 4'h4, 4'h1, 4'h3, 4'h2, 4'h8, 4'h9, 4'hA, 4'h0, 4'hF};
    logic [15:0] t_a   [12] = '{16'h7878, 16'h8000, 16'h0001, 16'h0001, 16'h8000, 16'h1234,
                                16'h5555, 16'hABCD, 16'hABCD, 16'h1001, 16'h4000, 16'h1111};
    logic [15:0] t_b   [12] = '{16'h1111, 16'h000F, 16'h0001, 16'h0004, 16'h0001, 16'h5678,
                                16'h5555, 16'h0012, 16'h0034, 16'h0002, 16'h4000, 16'h2222};
    logic [15:0] t_res [12] = '{16'h7979, 16'hFFFF, 16'h8000, 16'h0010, 16'h7FFF, 16'h0000,
                                16'h0000, 16'hAB12, 16'h34CD, 16'h1004, 16'h8000, 16'h0000};
    logic [2:0]  t_flg [12] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010,
                                3'b110, 3'b110, 3'b110, 3'b110, 3'b011, 3'b011};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flag", flag, 0);

        // ADD overflow, latency n+2
        drive(4'h0, 16'h7FFF, 16'h0001);
        tick(); in_valid = 1'b0;
        check("add_n1_valid", out_valid, 0);
        tick();
        check("add_valid", out_valid, 1);
        check("add_result", result, 16'h8000);
        tick();
        check("add_flag", flag, 3'b011);

        // SUB then XOR back-to-back
        drive(4'h1, 16'h1234, 16'h1234);
        tick(); drive(4'h2, 16'hFFFF, 16'h0000);
        tick(); in_valid = 1'b0;
        check("sub_valid", out_valid, 1);
        check("sub_result", result, 16'h0000);
        tick();
        check("xor_result", result, 16'hFFFF);
        check("sub_flag", flag, 3'b100);
        tick();
        check("xor_flag", flag, 3'b000);
        check("xor_drain", out_valid, 0);

        // Opcode table at full throughput
        for (int k = 0; k < 15; k++) begin
            if (k >= 2 && k < 14) begin
                check($sformatf("tbl%0d_valid", k-2), out_valid, 1);
                check($sformatf("tbl%0d_result", k-2), result, t_res[k-2]);
            end
            if (k >= 3) check($sformatf("tbl%0d_flag", k-3), flag, t_flg[k-3]);
            if (k < 12) drive(t_op[k], t_a[k], t_b[k]);
            else in_valid = 1'b0;
            tick();
        end

        // Backpressure: A=ADD 1+1, B=ADD 7FFF+1, C=XOR FFFF^FFFF, D=SUB 5-3
        out_ready = 1'b0;
        drive(4'h0, 16'h0001, 16'h0001);
        check("bp_rdy0", in_ready, 1);
        tick(); drive(4'h0, 16'h7FFF, 16'h0001);
        check("bp_rdy1", in_ready, 1);
        tick(); drive(4'h2, 16'hFFFF, 16'hFFFF);
        check("bp_rdy2", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_hold%0d_valid", i), out_valid, 1);
            check($sformatf("bp_hold%0d_result", i), result, 16'h0002);
            check($sformatf("bp_hold%0d_flag", i), flag, 3'b011);
            check($sformatf("bp_hold%0d_rdy", i), in_ready, 0);
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        tick(); drive(4'h1, 16'h0005, 16'h0003);
        check("bp_B_result", result, 16'h8000);
        check("bp_A_flag", flag, 3'b000);
        tick(); in_valid = 1'b0;
        check("bp_C_result", result, 16'h0000);
        check("bp_B_flag", flag, 3'b011);
        tick();
        check("bp_D_result", result, 16'h0002);
        check("bp_C_flag", flag, 3'b111);
        tick();
        check("bp_D_flag", flag, 3'b000);
        check("bp_drain", out_valid, 0);

        // Reset mid-stream with a result pending
        drive(4'h0, 16'h7FFF, 16'h0001);
        tick(); drive(4'h0, 16'h0001, 16'h0001);
        tick(); in_valid = 1'b0;
        tick();
        check("rm_pre_flag", flag, 3'b011);
        check("rm_pre_valid", out_valid, 1);
        out_ready = 1'b0; rst = 1'b1;
        drive(4'h0, 16'h0003, 16'h0003);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rm_valid", out_valid, 0);
        check("rm_flag", flag, 3'b000);
        check("rm_result", result, 16'h0000);
        check("rm_rdy", in_ready, 1);
        out_ready = 1'b1;
        tick(); tick();
        check("rm_lost", out_valid, 0);

`ifdef ALU_PIPE_MUL_EN
        drive(4'hB, 16'h0100, 16'h0100);
        tick(); in_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("mul_busy%0d", i), in_ready, 0);
            tick();
        end
        check("mul_n17_valid", out_valid, 0);
        tick();
        check("mul_valid", out_valid, 1);
        check("mul_result", result, 16'h0000);
        tick();
        check("mul_flag", flag, 3'b110);
`else
        drive(4'h0, 16'h4000, 16'h4000);
        tick(); drive(4'hB, 16'h0100, 16'h0100);
        tick(); in_valid = 1'b0;
        tick();
        check("rsv_b_result", result, 16'h0000);
        check("rsv_b_valid", out_valid, 1);
        tick();
        check("rsv_b_flag", flag, 3'b011);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
